// File: rtl/ff_fde.sv
// ff_fde: WIDTH-bit D flip-flop with a clock enable and an asynchronous active-low reset.
// The enable is a data-path mux in front of the register; the clock is never gated.
module ff_fde #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_enable,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_q
);
    logic [WIDTH-1:0] r_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_q <= RST_VAL;
        else if (i_enable)
            r_q <= i_data;
    end

    assign o_q = r_q;
endmodule

// File: tb/tb_ff_fde.sv
// tb_ff_fde: directed checks of ff_fde at WIDTH=1 and at WIDTH=8 with RST_VAL=8'hA5.
// Expected values are queued when stimulus is driven and popped when q is sampled.
module tb_ff_fde;
    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       en1   = 1'b0;
    logic       d1    = 1'b0;
    logic       q1;
    logic       en8   = 1'b0;
    logic [7:0] d8    = 8'h00;
    logic [7:0] q8;

    int         passed = 0;
    int         total  = 0;
    logic [7:0] exp_q[$];
    string      tag_q[$];

    always #20 clk = ~clk;

    ff_fde u_w1 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_enable(en1),
        .i_data  (d1),
        .o_q     (q1)
    );

    ff_fde #(.WIDTH(8), .RST_VAL(8'hA5)) u_w8 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_enable(en8),
        .i_data  (d8),
        .o_q     (q8)
    );

    task automatic push(input string t, input logic [7:0] e);
        tag_q.push_back(t);
        exp_q.push_back(e);
    endtask

    task automatic check(input logic [7:0] obs);
        string      t;
        logic [7:0] e;
        total++;
        if (exp_q.size() == 0) begin
            $error("FAIL scoreboard_empty: observed %h with no expected value", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) passed++;
            else $error("FAIL %s: observed %h expected %h", t, obs, e);
        end
    endtask

    task automatic step1(input logic e, input logic d, input logic x, input string t);
        @(negedge clk);
        en1 = e;
        d1  = d;
        push(t, {7'b0, x});
        @(posedge clk);
        #1 check({7'b0, q1});
    endtask

    task automatic step8(input logic e, input logic [7:0] d, input logic [7:0] x, input string t);
        @(negedge clk);
        en8 = e;
        d8  = d;
        push(t, x);
        @(posedge clk);
        #1 check(q8);
    endtask

    initial begin
        // Reset asserted between edges must take effect at once on both instances.
        #2 rst_n = 1'b0;
        #1;
        push("rst_w1", 8'h00); check({7'b0, q1});
        push("rst_w8", 8'hA5); check(q8);
        // Enable and data active while reset is held: reset wins.
        en1 = 1'b1; d1 = 1'b1; en8 = 1'b1; d8 = 8'h5A;
        repeat (2) begin
            @(posedge clk);
            #1;
            push("rst_hold_w1", 8'h00); check({7'b0, q1});
            push("rst_hold_w8", 8'hA5); check(q8);
        end
        @(negedge clk);
        rst_n = 1'b1; en1 = 1'b0; en8 = 1'b0;

        // Scenario 1: hold after reset
        step1(1'b0, 1'b1, 1'b0, "hold_a");
        step1(1'b0, 1'b1, 1'b0, "hold_b");

        // Scenario 2: capture, not before the edge
        @(negedge clk);
        en1 = 1'b1; d1 = 1'b1;
        #15;
        push("cap_before_edge", 8'h00); check({7'b0, q1});
        push("cap_one", 8'h01);
        @(posedge clk);
        #1 check({7'b0, q1});
        step1(1'b1, 1'b0, 1'b0, "cap_zero");

        // Scenario 3: disabled hold with toggling data, q=0 then q=1
        step1(1'b0, 1'b1, 1'b0, "dis0_a");
        step1(1'b0, 1'b0, 1'b0, "dis0_b");
        step1(1'b0, 1'b1, 1'b0, "dis0_c");
        step1(1'b1, 1'b1, 1'b1, "load_one");
        step1(1'b0, 1'b0, 1'b1, "dis1_a");
        step1(1'b0, 1'b1, 1'b1, "dis1_b");
        step1(1'b0, 1'b0, 1'b1, "dis1_c");

        // Scenario 4: async reset mid-run
        en1 = 1'b1; d1 = 1'b1;
        @(posedge clk);
        #5 rst_n = 1'b0;
        #1;
        push("arst_imm", 8'h00); check({7'b0, q1});
        push("arst_imm_w8", 8'hA5); check(q8);
        repeat (2) begin
            @(posedge clk);
            #1;
            push("arst_held", 8'h00); check({7'b0, q1});
        end
        @(negedge clk);
        rst_n = 1'b1; en1 = 1'b1; d1 = 1'b1;
        push("arst_release", 8'h01);
        @(posedge clk);
        #1 check({7'b0, q1});

        // Scenario 6: data changes 5 ns after an edge
        @(posedge clk);
        #5 d1 = 1'b0;
        #1;
        push("samp_hold", 8'h01); check({7'b0, q1});
        push("samp_next", 8'h00);
        @(posedge clk);
        #1 check({7'b0, q1});

        // Scenario 5: WIDTH=8 with RST_VAL=8'hA5
        step8(1'b0, 8'h77, 8'hA5, "w8_hold_rst");
        step8(1'b1, 8'h3C, 8'h3C, "w8_cap");
        step8(1'b0, 8'hFF, 8'h3C, "w8_dis_a");
        step8(1'b0, 8'hFF, 8'h3C, "w8_dis_b");
        step8(1'b1, 8'hC3, 8'hC3, "w8_cap2");

        if (exp_q.size() != 0) begin
            total++;
            $error("FAIL scoreboard_leftover: observed %0d entries expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/ff_fde.md
FF_FDE -- requirements
Module: ff_fde

Interface
REQ-001 Parameter WIDTH, default 1, data/q bit width, legal range 1..64.
REQ-002 Parameter RST_VAL, default all-zeros (WIDTH bits), value loaded into q on reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 enable  input  1  clock enable, active-high.
REQ-006 data  input  WIDTH  D input.
REQ-007 q  output  WIDTH  registered output.
REQ-008 The design SHALL use one clock and an asynchronous active-low reset, with no other clock or reset inputs.

Function
REQ-009 q SHALL be driven directly from a register, with no combinational path from data or enable to q.
REQ-010 On a rising clk edge with rst_n=1 and enable=1, q SHALL take the value of data sampled at that edge, with 1-cycle latency.
REQ-011 On a rising clk edge with rst_n=1 and enable=0, q SHALL hold its previous value.
REQ-012 Changes on data or enable between rising edges SHALL NOT affect q.
REQ-013 Changes on data while enable=0 SHALL NOT affect q at any later edge unless enable=1 at that edge.
REQ-014 enable SHALL be sampled only at the rising edge, with no glitch or latch behaviour, and SHALL NOT be implemented by gating clk.
REQ-015 All WIDTH bits SHALL update together under the single enable, with no per-bit enables.
REQ-016 If enable and reset are asserted at the same edge, reset SHALL win and q SHALL equal RST_VAL.
REQ-017 After power-up and before the first reset, q is undefined; the bench SHALL NOT check q in this window.

Reset
REQ-018 When rst_n falls, q SHALL equal RST_VAL immediately, without waiting for a clk edge.
REQ-019 While rst_n=0, q SHALL hold RST_VAL regardless of clk, enable or data.
REQ-020 Reset asserted mid-operation SHALL discard the held value.
REQ-021 The first rising edge with rst_n=1 SHALL be a normal capture/hold edge per REQ-010/REQ-011.
REQ-022 rst_n deassertion SHALL be treated as synchronous to clk by the integrator.
REQ-023 The block SHALL contain no internal reset synchronizer.

Verification
(clk period 40 ns; rst_n pulsed low at start; WIDTH=1 unless stated)
REQ-024 Scenario 1 (hold): rst_n=0 then 1, enable=0, data=1 for 2 edges -> q stays 0.
REQ-025 Scenario 2 (capture): enable=1, data=1 -> q=1 at the next rising edge and not before; then data=0 with enable=1 -> q=0 at the following edge.
REQ-026 Scenario 3 (disable hold): q=0, enable=0, data toggled 0/1 over 3 edges -> q stays 0; likewise with q=1 -> q stays 1.
REQ-027 Scenario 4 (async reset mid-run): q=1, enable=1, rst_n driven low between edges -> q=0 before the next edge and held through 2 edges; rst_n high, data=1 -> q=1 at the first edge after release.
REQ-028 Scenario 5 (width/reset value): WIDTH=8, RST_VAL=8'hA5, reset -> q=8'hA5; enable=1, data=8'h3C -> q=8'h3C next edge; enable=0, data=8'hFF -> q stays 8'h3C.
REQ-029 Scenario 6 (sampling): data changes 5 ns after an edge with enable=1 -> q changes only at the next edge, to the new value.
